// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : APB completer with a small word-addressed register file.
//            Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are
//            read/write. A programmable number of wait states is inserted
//            in every access phase. Bad accesses get an error response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Hclk     in   1   clock, rising edge
//   Hresetn  in   1   asynchronous active-low reset
//   Pselx    in   3   slave selects; only bit SLV_IDX belongs to this slave
//   Penable  in   1   access-phase strobe
//   Pwrite   in   1   1 = write, 0 = read
//   Paddr    in  32   byte address (bits [5:2] index the register file)
//   Pwdata   in  32   write data
//   Prdata   out 32   read data, zero unless a clean read is completing
//   Pready   out  1   transfer-complete strobe
//   Pslverr  out  1   error response, only meaningful while Pready=1
// ============================================================================
module apb_slave_regfile #(
  parameter int          SLV_IDX     = 0,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [3:0] C_WAIT  = 4'(WAIT_STATES);
  localparam logic [4:0] C_NREGS = 5'(NUM_REGS);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        sel;
  logic [3:0]  idx;
  logic        addr_ok;
  logic        err;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [31:0] rd_words [16];

  // The bridge has already decoded the region, so the upper address bits
  // and the other slaves' select lines carry no information here.
  logic        unused_bits;
  assign unused_bits = ^{Paddr[31:6], Pselx};

  assign sel     = Pselx[SLV_IDX];
  assign idx     = Paddr[5:2];
  assign addr_ok = (Paddr[1:0] == 2'b00) && ({1'b0, idx} < C_NREGS);
  // Register 0 is the read-only ID word, so writing it is an error.
  assign err     = !addr_ok || (Pwrite && (idx == 4'd0));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Only a proper setup phase starts a transfer; an access phase
        // without a preceding setup is ignored.
        if (sel && !Penable) begin
          state_d = ST_ACCESS;
          cnt_d   = C_WAIT;
        end
      end
      ST_ACCESS: begin
        if (sel && Penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          // Abort. Even if this edge looks like a fresh setup, the master
          // has to present setup again from IDLE.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: purely from registered state and the live bus inputs, so
  // the async reset forces all outputs to zero at once.
  // --------------------------------------------------------------------------
  always_comb begin
    Pready  = 1'b0;
    Pslverr = 1'b0;
    Prdata  = 32'd0;
    if ((state_q == ST_ACCESS) && (cnt_q == 4'd0) && sel && Penable) begin
      Pready  = 1'b1;
      Pslverr = err;
      if (!Pwrite && !err) begin
        Prdata = rd_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  assign wr_en = Pready && Pwrite && !err;

  for (genvar i = 0; i < 16; i++) begin : g_reg
    if (i == 0) begin : g_id
      assign rd_words[i] = ID_VALUE;
    end else if (i < NUM_REGS) begin : g_rw
      logic [31:0] reg_q;
      always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
          reg_q <= 32'd0;
        end else if (wr_en && (idx == 4'(i))) begin
          reg_q <= Pwdata;
        end
      end
      assign rd_words[i] = reg_q;
    end else begin : g_none
      // Unimplemented slots; reads of these indices are errored anyway.
      assign rd_words[i] = 32'd0;
    end
  end

  assign rd_word = rd_words[idx];

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Purpose  : Self-checking bench. Three slaves share one APB bus, each on
//            its own Pselx bit with a different wait-state count (0, 2, 3).
//            A transaction-level model predicts every slave's outputs for
//            every cycle; a negedge process compares them. A few literal
//            expectations pin the model to hand-computed values.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : none
// ============================================================================
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;
  localparam int WS [3] = '{0, 2, 3};

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  logic [31:0] prdata_w [3];
  logic [2:0]  pready_w;
  logic [2:0]  pslverr_w;

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.SLV_IDX(0), .NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(ID)) u_s0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata_w[0]), .Pready(pready_w[0]), .Pslverr(pslverr_w[0]));

  apb_slave_regfile #(.SLV_IDX(1), .NUM_REGS(8), .WAIT_STATES(2), .ID_VALUE(ID)) u_s1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata_w[1]), .Pready(pready_w[1]), .Pslverr(pslverr_w[1]));

  apb_slave_regfile #(.SLV_IDX(2), .NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(ID)) u_s2 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata_w[2]), .Pready(pready_w[2]), .Pslverr(pslverr_w[2]));

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] mregs [3][16];
  logic [2:0]  exp_rdy;
  logic [2:0]  exp_err;
  logic [31:0] exp_rd [3];

  logic        pend_v;
  int          pend_s;
  logic [3:0]  pend_i;
  logic [31:0] pend_d;

  function automatic logic m_err(input logic wr, input logic [31:0] a);
    logic [3:0] i;
    i = a[5:2];
    return (a[1:0] != 2'b00) || (i >= 4'd8) || (wr && (i == 4'd0));
  endfunction

  function automatic logic [31:0] m_rd(input int s, input logic [31:0] a);
    if (a[5:2] == 4'd0) return ID;
    return mregs[s][a[5:2]];
  endfunction

  task automatic clear_exp();
    exp_rdy = 3'b000;
    exp_err = 3'b000;
    for (int s = 0; s < 3; s++) exp_rd[s] = 32'd0;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++) mregs[s][i] = 32'd0;
    pend_v = 1'b0;
  endtask

  // Advance to just after the next rising edge; a write that completed on
  // that edge becomes visible in the model.
  task automatic step();
    @(posedge Hclk);
    #1;
    if (pend_v) begin
      mregs[pend_s][pend_i] = pend_d;
      pend_v = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge Hclk) begin
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rdy s%0d", s), {31'd0, pready_w[s]},  {31'd0, exp_rdy[s]});
      check($sformatf("err s%0d", s), {31'd0, pslverr_w[s]}, {31'd0, exp_err[s]});
      check($sformatf("rd s%0d", s),  prdata_w[s],           exp_rd[s]);
    end
  end

  int rdy_cnt1 = 0;
  always @(negedge Hclk) if (pready_w[1] === 1'b1) rdy_cnt1++;

  // ---------------- stimulus tasks ----------------
  // Setup phase followed by n_acc access cycles (n_acc<0: run to completion).
  // With lit=1 the completing cycle is also checked against literals.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int n_acc, input logic lit,
                      input logic [31:0] lit_rd, input logic lit_err);
    int  n;
    logic e;
    n = (n_acc < 0) ? WS[s] + 1 : n_acc;
    step();
    Pselx = 3'(1 << s); Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = d;
    clear_exp();
    for (int k = 0; k < n; k++) begin
      step();
      Penable = 1'b1;
      clear_exp();
      if (k == WS[s]) begin
        e = m_err(wr, a);
        exp_rdy[s] = 1'b1;
        exp_err[s] = e;
        exp_rd[s]  = (!wr && !e) ? m_rd(s, a) : 32'd0;
        if (wr && !e) begin
          pend_v = 1'b1; pend_s = s; pend_i = a[5:2]; pend_d = d;
        end
        if (lit) begin
          #2;
          check($sformatf("lit rdy s%0d a=%0h", s, a), {31'd0, pready_w[s]}, 32'd1);
          check($sformatf("lit err s%0d a=%0h", s, a), {31'd0, pslverr_w[s]}, {31'd0, lit_err});
          check($sformatf("lit rd s%0d a=%0h", s, a),  prdata_w[s], lit_rd);
        end
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      step();
      Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'd0; Pwdata = 32'd0;
      clear_exp();
    end
  endtask

  // Assert reset between clock edges, confirm outputs drop at once, hold
  // for two edges and release.
  task automatic reset_pulse();
    Hresetn = 1'b0;
    clear_exp();
    clear_model();
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("async rdy s%0d", s), {31'd0, pready_w[s]},  32'd0);
      check($sformatf("async err s%0d", s), {31'd0, pslverr_w[s]}, 32'd0);
      check($sformatf("async rd s%0d", s),  prdata_w[s],           32'd0);
    end
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    step();
    step();
    Hresetn = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int r0;

  initial begin
    Hresetn = 1'b0;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'd0; Pwdata = 32'd0;
    clear_model();
    clear_exp();
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset rdy s%0d", s), {31'd0, pready_w[s]}, 32'd0);
      check($sformatf("reset rd s%0d", s),  prdata_w[s],          32'd0);
    end
    step();
    step();
    Hresetn = 1'b1;

    // 1: ID read with zero waits, then an empty register.
    xfer(0, 1'b0, 32'h00, 32'd0, -1, 1'b1, ID, 1'b0);
    xfer(0, 1'b0, 32'h0C, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    idle(1);

    // 2: back-to-back write/read with two wait states.
    r0 = rdy_cnt1;
    xfer(1, 1'b1, 32'h0C, 32'hDEAD_BEEF, -1, 1'b0, 32'd0, 1'b0);
    xfer(1, 1'b0, 32'h0C, 32'd0, -1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    check("t2 ready pulses", 32'(rdy_cnt1 - r0), 32'd2);
    xfer(0, 1'b0, 32'h0C, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    xfer(2, 1'b0, 32'h0C, 32'd0, -1, 1'b1, 32'd0, 1'b0);

    // 3: error responses.
    xfer(0, 1'b1, 32'h00, 32'h1111_1111, -1, 1'b1, 32'd0, 1'b1);
    xfer(0, 1'b0, 32'h20, 32'd0, -1, 1'b1, 32'd0, 1'b1);
    xfer(0, 1'b0, 32'h05, 32'd0, -1, 1'b1, 32'd0, 1'b1);
    xfer(2, 1'b1, 32'h3C, 32'h2222_2222, -1, 1'b1, 32'd0, 1'b1);
    xfer(0, 1'b0, 32'h00, 32'd0, -1, 1'b1, ID, 1'b0);
    xfer(1, 1'b0, 32'h1C, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    idle(1);

    // 4: select drop in the middle of the wait states.
    xfer(2, 1'b1, 32'h08, 32'h1234_5678, 1, 1'b0, 32'd0, 1'b0);
    idle(2);
    xfer(2, 1'b0, 32'h08, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    idle(1);

    // 4b: abort that looks like a new setup, then access without setup.
    xfer(1, 1'b1, 32'h18, 32'hCAFE_0000, 1, 1'b0, 32'd0, 1'b0);
    step(); Penable = 1'b0; clear_exp();
    repeat (4) begin
      step(); Penable = 1'b1; clear_exp();
    end
    idle(1);
    xfer(1, 1'b0, 32'h18, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    idle(1);

    // 5: access without setup from IDLE.
    step();
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'hFFFF_0000;
    clear_exp();
    repeat (4) step();
    idle(1);
    xfer(0, 1'b0, 32'h10, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    idle(1);

    // 6: async reset while Pready is high, then while a write is waiting.
    xfer(1, 1'b1, 32'h04, 32'h0BAD_F00D, -1, 1'b0, 32'd0, 1'b0);
    xfer(1, 1'b0, 32'h04, 32'd0, -1, 1'b1, 32'h0BAD_F00D, 1'b0);
    xfer(0, 1'b0, 32'h00, 32'd0, -1, 1'b1, ID, 1'b0);
    reset_pulse();
    xfer(1, 1'b0, 32'h04, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    xfer(1, 1'b1, 32'h04, 32'h0BAD_F00D, -1, 1'b0, 32'd0, 1'b0);
    xfer(1, 1'b1, 32'h04, 32'h0000_0055, 2, 1'b0, 32'd0, 1'b0);
    #2;
    reset_pulse();
    xfer(1, 1'b0, 32'h04, 32'd0, -1, 1'b1, 32'd0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
